inv_mod_param: RTL and testbench



---
 rtl/inv_mod_if.sv | 13 +
 rtl/inv_mod_param.sv | 135 +++++++++++++
 tb/tb_inv_mod_param.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/inv_mod_if.sv
// inv_mod_if: operand/result handshake bundle for inv_mod_param.
interface inv_mod_if #(parameter int WIDTH = 256);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opM;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_err;
    modport master (output in_valid, opA, opM, out_ready, input in_ready, out_valid, out_data, out_err);
    modport slave  (input in_valid, opA, opM, out_ready, output in_ready, out_valid, out_data, out_err);
endinterface

// File: rtl/inv_mod_param.sv
// inv_mod_param: binary extended-Euclid modular inverse, one reduction step per clock.
// Defining INV_MOD_CYC_CNT_EN adds the cyc_cnt output (RUN cycles of the last result).
module inv_mod_param #(
    parameter int WIDTH = 256,
    parameter int MAX_CYC = 2*WIDTH+2,
    localparam int CW = $clog2(MAX_CYC+1)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef INV_MOD_CYC_CNT_EN
    output logic [CW-1:0] cyc_cnt,
`endif
    inv_mod_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [WIDTH-1:0] u_q, u_d, v_q, v_d, x1_q, x1_d, x2_q, x2_d, m_q, m_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cyc_q, cyc_d;
    logic [WIDTH:0]   x1_sum, x2_sum, x1_dif, x2_dif;
    logic [WIDTH-1:0] x1_sub, x2_sub;
    logic             illegal, accept;
    always_comb begin
        illegal = !bus.opM[0] || bus.opM < WIDTH'(3) || bus.opA == '0 || bus.opA >= bus.opM;
        accept  = bus.in_valid && rdy_q;
        // Halving an odd x first adds m; the carry lives in bit WIDTH and is shifted back down.
        x1_sum  = {1'b0, x1_q} + (x1_q[0] ? {1'b0, m_q} : '0);
        x2_sum  = {1'b0, x2_q} + (x2_q[0] ? {1'b0, m_q} : '0);
        x1_dif  = {1'b0, x1_q} - {1'b0, x2_q};
        x2_dif  = {1'b0, x2_q} - {1'b0, x1_q};
        x1_sub  = x1_dif[WIDTH] ? x1_dif[WIDTH-1:0] + m_q : x1_dif[WIDTH-1:0];
        x2_sub  = x2_dif[WIDTH] ? x2_dif[WIDTH-1:0] + m_q : x2_dif[WIDTH-1:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            m_q     <= '0;
            cyc_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            m_q     <= m_d;
            cyc_q   <= cyc_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        m_d     = m_q;
        cyc_d   = cyc_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept && illegal) begin
                    state_d = DONE;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else if (accept) begin
                    state_d = RUN;
                    u_d     = bus.opA;
                    v_d     = bus.opM;
                    x1_d    = WIDTH'(1);
                    x2_d    = '0;
                    m_d     = bus.opM;
                    cyc_d   = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_q + CW'(1);
                if (u_q == WIDTH'(1)) begin
                    state_d = DONE;
                    data_d  = x1_q;
                    err_d   = 1'b0;
                end else if (v_q == WIDTH'(1)) begin
                    state_d = DONE;
                    data_d  = x2_q;
                    err_d   = 1'b0;
                end else if (u_q == '0 || v_q == '0 || cyc_q == CW'(MAX_CYC-1)) begin
                    state_d = DONE;
                    data_d  = '0;
                    err_d   = 1'b1;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = x1_sum[WIDTH:1];
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = x2_sum[WIDTH:1];
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = x1_sub;
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = x2_sub;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        rdy_d = state_d == IDLE;
    end
    always_comb begin
        bus.in_ready  = rdy_q;
        bus.out_valid = state_q == DONE;
        bus.out_data  = data_q;
        bus.out_err   = err_q;
    end
`ifdef INV_MOD_CYC_CNT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (state_d == DONE && state_q != DONE) ? (state_q == RUN ? cyc_q + CW'(1) : '0) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign cyc_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_inv_mod_param.sv
// tb_inv_mod_param: scoreboard bench for 16-bit and 256-bit inv_mod_param instances.
module tb_inv_mod_param;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    inv_mod_if #(.WIDTH(16))  b16();
    inv_mod_if #(.WIDTH(256)) b256();
`ifdef INV_MOD_CYC_CNT_EN
    logic [5:0] cc16;
    logic [9:0] cc256;
    inv_mod_param #(.WIDTH(16))  d16  (.clk(clk), .rst(rst), .cyc_cnt(cc16),  .bus(b16));
    inv_mod_param #(.WIDTH(256)) d256 (.clk(clk), .rst(rst), .cyc_cnt(cc256), .bus(b256));
`else
    inv_mod_param #(.WIDTH(16))  d16  (.clk(clk), .rst(rst), .bus(b16));
    inv_mod_param #(.WIDTH(256)) d256 (.clk(clk), .rst(rst), .bus(b256));
`endif
    typedef struct {logic [255:0] data; logic err; int cnt;} exp_t;
    exp_t q16[$], q256[$];
    exp_t e16, e256;
    int compared = 0, mismatched = 0;
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Euclid with signed coefficients; -1 when gcd != 1.
    function automatic longint ext_inv(input longint a, input longint m);
        longint r0, r1, t0, t1, q, tmp;
        r0 = m; r1 = a; t0 = 0; t1 = 1;
        while (r1 != 0) begin
            q = r0 / r1;
            tmp = r0 - q * r1; r0 = r1; r1 = tmp;
            tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        end
        if (r0 != 1) return -1;
        return t0 < 0 ? t0 + m : t0;
    endfunction
    // Counts reduction steps of the binary algorithm on (u,v) alone to predict cycle count and watchdog.
    function automatic exp_t predict(input logic [255:0] a, input logic [255:0] m, input logic [255:0] inv, input int max_cyc);
        exp_t e;
        logic [255:0] u, v;
        u = a; v = m;
        e.data = '0; e.err = 1'b1; e.cnt = 0;
        if (!m[0] || m < 3 || a == 0 || a >= m) return e;
        while (e.cnt <= max_cyc) begin
            e.cnt++;
            if (u == 1 || v == 1) begin
                e.err = 1'b0; e.data = inv;
                return e;
            end
            if (u == 0 || v == 0 || e.cnt == max_cyc) return e;
            if (!u[0]) u = u >> 1;
            else if (!v[0]) v = v >> 1;
            else if (u >= v) u = u - v;
            else v = v - u;
        end
        return e;
    endfunction
    always @(negedge clk) if (!rst && b16.out_valid && b16.out_ready) begin
        if (q16.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected16: got %0h expected none", b16.out_data);
        end else begin
            e16 = q16.pop_front();
            check("data16", b16.out_data, e16.data);
            check("err16", b16.out_err, e16.err);
`ifdef INV_MOD_CYC_CNT_EN
            check("cyc_cnt16", cc16, e16.cnt);
`endif
        end
    end
    always @(negedge clk) if (!rst && b256.out_valid && b256.out_ready) begin
        if (q256.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected256: got %0h expected none", b256.out_data);
        end else begin
            e256 = q256.pop_front();
            check("data256", b256.out_data, e256.data);
            check("err256", b256.out_err, e256.err);
`ifdef INV_MOD_CYC_CNT_EN
            check("cyc_cnt256", cc256, e256.cnt);
`endif
        end
    end
    task automatic run(input bit big, input logic [255:0] a, input logic [255:0] m, input logic [255:0] inv, input bit hold);
        exp_t e;
        int lat;
        e = predict(a, m, inv, big ? 514 : 34);
        lat = 0;
        if (big) begin
            q256.push_back(e);
            b256.opA = a; b256.opM = m; b256.in_valid = 1'b1;
        end else begin
            q16.push_back(e);
            b16.opA = a[15:0]; b16.opM = m[15:0]; b16.in_valid = 1'b1; b16.out_ready = !hold;
        end
        while (!(big ? b256.in_ready : b16.in_ready) && lat < 50) begin
            @(negedge clk); lat++;
        end
        check("in_ready_accept", big ? b256.in_ready : b16.in_ready, 1);
        @(posedge clk); #1;
        b16.in_valid = 1'b0; b256.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!(big ? b256.out_valid : b16.out_valid) && lat < 2000);
        check(big ? "latency256" : "latency16", lat, e.cnt + 1);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                b16.in_valid = 1'b1; b16.opA = 16'(i + 1); b16.opM = 16'd11;
                @(negedge clk);
                check("hold_valid", b16.out_valid, 1);
                check("hold_data", b16.out_data, e.data);
                check("hold_err", b16.out_err, e.err);
                check("hold_ready", b16.in_ready, 0);
            end
            @(posedge clk); #1;
            b16.in_valid = 1'b0; b16.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("in_ready_after", big ? b256.in_ready : b16.in_ready, 1);
        check("out_valid_drop", big ? b256.out_valid : b16.out_valid, 0);
    endtask
    initial begin
        logic [255:0] p, p_half;
        logic [15:0] ra, rm;
        longint iv;
        p = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
        p_half = (p >> 1) + 1;
        rst = 1'b0;
        b16.in_valid = 1'b0; b16.opA = '0; b16.opM = '0; b16.out_ready = 1'b1;
        b256.in_valid = 1'b0; b256.opA = '0; b256.opM = '0; b256.out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("reset_ready", b16.in_ready, 0);
        check("reset_valid", b16.out_valid, 0);
        check("reset_data", b16.out_data, 0);
        check("reset_err", b16.out_err, 0);
        check("reset_valid256", b256.out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", b16.in_ready, 1);
        run(0, 3, 7, 5, 0);
        run(0, 10, 17, 12, 0);
        run(0, 6, 9, 0, 0);
        run(0, 3, 8, 0, 0);
        run(0, 9, 9, 0, 0);
        run(0, 0, 7, 0, 0);
        run(0, 1, 1, 0, 0);
        run(0, 1, 7, 1, 0);
        run(0, 6, 7, 6, 0);
        run(0, 13, 23, 16, 1);
        // Abort an operation mid-RUN; outputs must clear without waiting for a clock.
        b16.opA = 16'd3; b16.opM = 16'd7; b16.in_valid = 1'b1;
        @(posedge clk); #1 b16.in_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("rst_mid_valid", b16.out_valid, 0);
        check("rst_mid_data", b16.out_data, 0);
        check("rst_mid_err", b16.out_err, 0);
        check("rst_mid_ready", b16.in_ready, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst_mid", b16.in_ready, 1);
        run(0, 3, 7, 5, 0);
        run(1, 2, p, p_half, 0);
        run(1, p - 1, p, p - 1, 0);
        run(1, 0, p, 0, 0);
        for (int i = 0; i < 1000; i++) begin
            rm = 16'($urandom_range(3, 65535)) | 16'd1;
            ra = (i % 16 == 0) ? 16'($urandom) : 16'($urandom_range(1, 32'(rm) - 1));
            iv = ext_inv(longint'(ra), longint'(rm));
            run(0, 256'(ra), 256'(rm), iv < 0 ? 256'd0 : 256'(iv), 0);
        end
        repeat (3) @(posedge clk);
        check("queue16_empty", q16.size(), 0);
        check("queue256_empty", q256.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
